// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller for the 5-stage RV32I core: load-use interlock, taken-branch
// flush, memory-handshake freeze, data-memory watchdog and saturating performance counters.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif

module hazard_ctrl #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [`RF_ADDR_WIDTH-1:0] idRs1,
    input  logic [`RF_ADDR_WIDTH-1:0] idRs2,
    input  logic                      idUsesRs1,
    input  logic                      idUsesRs2,
    input  logic                      idMemWrite,
    input  logic [`RF_ADDR_WIDTH-1:0] idexRd,
    input  logic                      idexMemRead,
    input  logic                      exBranchTaken,
    input  logic                      imemReady,
    input  logic                      exmemMemAccess,
    input  logic                      dmemReady,
    output logic                      pcWrite,
    output logic                      ifidWrite,
    output logic                      idexWrite,
    output logic                      exmemWrite,
    output logic                      ifidFlush,
    output logic                      idexFlush,
    output logic                      memwbBubble,
    output logic                      memErr,
    output logic [CNT_W-1:0]          stallCycles,
    output logic [CNT_W-1:0]          flushCount
);

    localparam int unsigned WaitW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               load_use, mem_stall, frozen, flush_taken;

    // A load feeding only the store-data operand is covered by forwarding into MEM.
    assign load_use = idexMemRead && (idexRd != '0) &&
                      ((idUsesRs1 && (idRs1 == idexRd)) ||
                       (idUsesRs2 && (idRs2 == idexRd) && !idMemWrite));
    assign mem_stall = exmemMemAccess && !dmemReady;
    assign frozen    = (state_q == StHalt) || mem_stall;

    always_comb begin
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        idexWrite   = 1'b1;
        exmemWrite  = 1'b1;
        ifidFlush   = 1'b0;
        idexFlush   = 1'b0;
        memwbBubble = 1'b0;
        flush_taken = 1'b0;
        if (!rst_n) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            exmemWrite  = 1'b0;
            ifidFlush   = 1'b1;
            idexFlush   = 1'b1;
            memwbBubble = 1'b1;
        end else if (frozen) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexWrite   = 1'b0;
            exmemWrite  = 1'b0;
            memwbBubble = 1'b1;
        end else if (exBranchTaken) begin
            ifidFlush   = 1'b1;
            idexFlush   = 1'b1;
            flush_taken = 1'b1;
        end else if (load_use) begin
            pcWrite     = 1'b0;
            ifidWrite   = 1'b0;
            idexFlush   = 1'b1;
        end else if (!imemReady) begin
            pcWrite     = 1'b0;
            ifidFlush   = 1'b1;
        end
    end

    // wait_cnt_q holds the number of not-ready cycles already completed.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StRun: begin
                if (mem_stall) begin
                    wait_cnt_d = WaitW'(1);
                    state_d    = (TIMEOUT == 1) ? StHalt : StMemWait;
                end
            end
            StMemWait: begin
                if (dmemReady) begin
                    wait_cnt_d = '0;
                    state_d    = StRun;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if ((TIMEOUT != 0) && ((32'(wait_cnt_q) + 32'd1) == TIMEOUT)) begin
                        state_d = StHalt;
                    end
                end
            end
            StHalt: ;
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pcWrite && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign memErr      = (state_q == StHalt);
    assign stallCycles = stall_cnt_q;
    assign flushCount  = flush_cnt_q;

endmodule
